serial_adder_ctrl: RTL and testbench

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

---
 rtl/serial_adder_ctrl_pkg.sv | 21 ++
 rtl/serial_adder_ctrl_full_adder_bit.sv | 29 ++
 rtl/serial_adder_ctrl.sv | 137 +++++++++++++
 tb/tb_serial_adder_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl_pkg
//   Shared definitions for the bit-serial adder controller:
//     - state encoding constants and the FSM state enum (IDLE, RUN, DONE)
//     - default operand/result width
// -----------------------------------------------------------------------------
package serial_adder_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

endpackage : serial_adder_ctrl_pkg

// File: rtl/serial_adder_ctrl_full_adder_bit.sv
// -----------------------------------------------------------------------------
// full_adder_bit
//   One-bit full adder made of two half-adder stages; the two half-adder
//   carries are ORed to form the carry-out.
//   Ports:
//     a, b  : input  operand bits
//     cin   : input  carry-in
//     s     : output sum bit
//     cout  : output carry-out
// -----------------------------------------------------------------------------
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic s1;   // first half adder: a + b
    logic c1;
    logic c2;   // second half adder: s1 + cin

    assign s1   = a ^ b;
    assign c1   = a & b;
    assign s    = s1 ^ cin;
    assign c2   = s1 & cin;
    assign cout = c1 | c2;

endmodule : full_adder_bit

// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//   Bit-serial adder: Sum = (A + B) mod 2^WIDTH, computed LSB first through a
//   single full_adder_bit over WIDTH RUN cycles.
//   Optional feature macro: SERIAL_ADDER_CARRY_EN (adds the Carry output).
//   Ports:
//     clk    : input  clock, rising-edge
//     rst_n  : input  asynchronous active-low reset
//     start  : input  begin an addition (only honoured in IDLE)
//     A, B   : input  operands, captured on the edge that accepts start
//     busy   : output high in RUN and DONE
//     done   : output one-cycle pulse in DONE, result valid
//     Sum    : output registered result, held until the next accepted start
//     Carry  : output final carry-out (only with SERIAL_ADDER_CARRY_EN)
// -----------------------------------------------------------------------------
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum
`ifdef SERIAL_ADDER_CARRY_EN
   ,output logic             Carry
`endif
);

    // Counts 0..WIDTH; sized so the final increment never wraps.
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   sum_q;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt;
    logic               accept;
    logic               last_bit;
    logic               fa_s;
    logic               fa_cout;

    assign accept   = (state == IDLE) && start;
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    // The one full adder, reused on every RUN cycle.
    full_adder_bit u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state and outputs
    // -------------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: operand shifters, result shifter, carry flop, bit counter
    // -------------------------------------------------------------------------
    // NOTE: the operand registers are plain flops, not a memory, so they are
    // reset along with everything else; reset must leave no stale operand.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
        end else if (accept) begin
            a_sh    <= A;
            b_sh    <= B;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
        end else if (state == RUN) begin
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            // LSB-first result enters at the MSB; after WIDTH shifts bit 0
            // holds the first computed bit.
            sum_q   <= {fa_s, sum_q[WIDTH-1:1]};
            // After the last RUN cycle this is the final carry-out; it is
            // left untouched until the next accepted start.
            carry_q <= fa_cout;
            cnt     <= cnt + CNT_W'(1);
        end
    end

    assign Sum = sum_q;

`ifdef SERIAL_ADDER_CARRY_EN
    assign Carry = carry_q;
`endif

endmodule : serial_adder_ctrl

// File: tb/tb_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_ctrl
//   Scoreboard bench: the driver pushes the arithmetic result and the edge on
//   which done must be seen; a negedge monitor pops and compares on done and
//   tracks busy and the held Sum/Carry every cycle.
// -----------------------------------------------------------------------------
module tb_serial_adder_ctrl;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] sum;
        logic         carry;
        int           done_edge;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
`ifdef SERIAL_ADDER_CARRY_EN
    logic         carry;
`endif

    int           edge_n    = 0;
    int           checks    = 0;
    int           failures  = 0;
    exp_t         sb[$];
    int           busy_from = 1;
    int           busy_to   = 0;
    int           next_free = 0;
    int           last_k    = 0;
    logic [W-1:0] held_sum  = '0;
    logic         held_carry = 1'b0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (a),
        .B     (b),
        .busy  (busy),
        .done  (done),
        .Sum   (sum)
`ifdef SERIAL_ADDER_CARRY_EN
       ,.Carry (carry)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, got, exp, edge_n);
        end
    endtask

    // Drive a request at the current negedge; the next rising edge accepts it.
    task automatic accept(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] full;
        full   = {1'b0, x} + {1'b0, y};
        a      = x;
        b      = y;
        start  = 1'b1;
        last_k = edge_n + 1;
        sb.push_back('{full[W-1:0], full[W], last_k + W});
        busy_from = last_k;
        busy_to   = last_k + W;
        next_free = last_k + W + 2;
    endtask

    task automatic release_start();
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
    endtask

    task automatic wait_free();
        while (edge_n + 1 < next_free) @(negedge clk);
    endtask

    // Monitor: busy every cycle, result on done, held result while idle.
    always @(negedge clk) begin
        exp_t e;
        logic exp_busy;
        if (rst_n === 1'b1) begin
            exp_busy = (edge_n >= busy_from) && (edge_n <= busy_to);
            check("busy", busy, exp_busy);
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", done, 1'b0);
                end else begin
                    e = sb.pop_front();
                    check("done_edge", edge_n, e.done_edge);
                    check("sum", sum, e.sum);
`ifdef SERIAL_ADDER_CARRY_EN
                    check("carry", carry, e.carry);
`endif
                    held_sum   = e.sum;
                    held_carry = e.carry;
                end
            end else if (sb.size() > 0 && edge_n > sb[0].done_edge) begin
                check("missed_done", done, 1'b1);
                void'(sb.pop_front());
            end
            if (!exp_busy) begin
                check("sum_held", sum, held_sum);
`ifdef SERIAL_ADDER_CARRY_EN
                check("carry_held", carry, held_carry);
`endif
            end
        end
    end

    initial begin
        logic hold;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_sum", sum, '0);
`ifdef SERIAL_ADDER_CARRY_EN
        check("rst_carry", carry, 1'b0);
`endif

        // First edge with reset released accepts start.
        rst_n = 1'b1;
        accept(8'h3C, 8'h5A);
        release_start();
        wait_free();

        accept(8'hFF, 8'h01);
        release_start();
        wait_free();

        // Restart attempt during RUN cycle 3 must be ignored.
        accept(8'h3C, 8'h5A);
        release_start();
        while (edge_n < last_k + 2) @(negedge clk);
        start = 1'b1;
        a     = 8'h11;
        b     = 8'h22;
        release_start();
        wait_free();

        // Reset in RUN cycle 4 discards the addition.
        accept(8'h3C, 8'h5A);
        release_start();
        while (edge_n < last_k + 3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_sum", sum, '0);
`ifdef SERIAL_ADDER_CARRY_EN
        check("midrst_carry", carry, 1'b0);
`endif
        sb.delete();
        busy_from  = 1;
        busy_to    = 0;
        held_sum   = '0;
        held_carry = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_no_done", done, 1'b0);
        rst_n = 1'b1;
        accept(8'h01, 8'h01);
        release_start();
        wait_free();

        // start held high: ignored in RUN and DONE, re-accepted in next IDLE.
        accept(8'h80, 8'h80);
        @(negedge clk);
        a = 8'hA5;
        b = 8'h5A;
        wait_free();
        accept(8'h80, 8'h80);
        @(negedge clk);
        a = 8'h33;
        b = 8'hCC;
        wait_free();
        start = 1'b0;

        // Randomized traffic, random gaps and random held start.
        hold = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            wait_free();
            if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
            accept(W'($urandom), W'($urandom));
            hold = 1'($urandom_range(0, 1));
            if (hold) begin
                @(negedge clk);
                a = W'($urandom);
                b = W'($urandom);
            end else begin
                release_start();
            end
        end
        @(negedge clk);
        wait_free();
        start = 1'b0;

        for (int i = 0; i < 4 * W && sb.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_serial_adder_ctrl
